sl_transmitter: RTL

Clocked two-wire SL line transmitter that serialises a parallel word of 1–32 data bits plus an odd-parity bit onto the sl0/sl1 pair, followed by an end-of-word marker. It sits directly upstream of the SL receiver and drives the line that the receiver decodes on falling edges.

- A data bit 0 is a low pulse on sl0 while sl1 is high.
- A data bit 1 is a low pulse on sl1 while sl0 is high.
- End of word is both lines low together.
- Bits are sent LSB first.

---
 rtl/sl_transmitter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sl_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : sl_transmitter
// Brief    : Two-wire SL line transmitter. Serialises 1..32 data bits (LSB
//            first) plus an odd-parity bit onto sl0/sl1, then sends an
//            end-of-word marker (both lines low together).
//            Optional feature macro: SL_TX_ERR_INJECT_EN adds inj_par_err,
//            which inverts the transmitted parity bit of the accepted word.
// Revision : 1.0 - initial release
// ============================================================================
module sl_transmitter #(
  parameter int PULSE_CYC = 4,   // clocks a line is held low per pulse (>=1)
  parameter int GAP_CYC   = 4    // clocks both lines are high after a pulse (>=1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  input  logic [5:0]  tx_len,
`ifdef SL_TX_ERR_INJECT_EN
  input  logic        inj_par_err,
`endif
  output logic        busy,
  output logic        done,
  output logic        len_err,
  output logic        sl0,
  output logic        sl1
);

  localparam int c_TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
  localparam logic [c_TMR_W-1:0] c_PULSE_LAST = c_TMR_W'(PULSE_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_GAP_LAST   = c_TMR_W'(GAP_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BIT_LOW   = 3'd1,
    S_BIT_HIGH  = 3'd2,
    S_STOP_LOW  = 3'd3,
    S_STOP_HIGH = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_TMR_W-1:0] r_tmr;
  logic [5:0]         r_bit_cnt;
  logic [5:0]         r_len;
  logic [30:0]        r_shift;   // data bits still to send; [0] is the next one
  logic               r_par;

  logic        w_len_ok;
  logic [31:0] w_mask;
  logic        w_par;
  logic [5:0]  w_next_cnt;
  logic        w_next_bit;

  // Request qualification and parity of the word being offered
  always_comb begin
    w_len_ok = (tx_len != 6'd0) && (tx_len <= 6'd32);
    w_mask   = (tx_len >= 6'd32) ? 32'hFFFF_FFFF
                                 : ((32'd1 << tx_len[4:0]) - 32'd1);
`ifdef SL_TX_ERR_INJECT_EN
    w_par    = (~^(tx_data & w_mask)) ^ inj_par_err;
`else
    w_par    = ~^(tx_data & w_mask);
`endif
    // The bit sent when the counter reaches the latched length is parity
    w_next_cnt = r_bit_cnt + 6'd1;
    w_next_bit = (w_next_cnt == r_len) ? r_par : r_shift[0];
  end

  // Word sequencer; line levels are registered alongside the state so that
  // both lines change on the same edge as the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_bit_cnt <= '0;
      r_len     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      sl0       <= 1'b1;
      sl1       <= 1'b1;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            if (w_len_ok) begin
              r_state   <= S_BIT_LOW;
              r_tmr     <= '0;
              r_bit_cnt <= '0;
              r_len     <= tx_len;
              r_shift   <= tx_data[31:1];
              r_par     <= w_par;
              // Bit 0 goes out straight away: 0 pulls sl0, 1 pulls sl1
              sl0       <= tx_data[0];
              sl1       <= ~tx_data[0];
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        S_BIT_LOW: begin
          if (r_tmr == c_PULSE_LAST) begin
            r_state <= S_BIT_HIGH;
            r_tmr   <= '0;
            sl0     <= 1'b1;
            sl1     <= 1'b1;
          end else begin
            r_tmr <= r_tmr + c_TMR_ONE;
          end
        end
        S_BIT_HIGH: begin
          if (r_tmr == c_GAP_LAST) begin
            r_tmr <= '0;
            if (r_bit_cnt == r_len) begin
              // Parity was the last bit; both lines fall together
              r_state <= S_STOP_LOW;
              sl0     <= 1'b0;
              sl1     <= 1'b0;
            end else begin
              r_state   <= S_BIT_LOW;
              r_bit_cnt <= w_next_cnt;
              r_shift   <= r_shift >> 1;
              sl0       <= w_next_bit;
              sl1       <= ~w_next_bit;
            end
          end else begin
            r_tmr <= r_tmr + c_TMR_ONE;
          end
        end
        S_STOP_LOW: begin
          if (r_tmr == c_PULSE_LAST) begin
            r_state <= S_STOP_HIGH;
            r_tmr   <= '0;
            sl0     <= 1'b1;
            sl1     <= 1'b1;
          end else begin
            r_tmr <= r_tmr + c_TMR_ONE;
          end
        end
        S_STOP_HIGH: begin
          if (r_tmr == c_GAP_LAST) begin
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            done      <= 1'b1;
          end else begin
            r_tmr <= r_tmr + c_TMR_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tmr   <= '0;
          sl0     <= 1'b1;
          sl1     <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready = (r_state == S_IDLE);
  assign busy     = ~tx_ready;

endmodule
`default_nettype wire
